// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, transfer
// direction codes and default bus widths.
package mem_responder_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, registered read, no reset so the
// contents survive a controller reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // The read register only moves on a read, so it keeps the last read word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MM/R_W/MAR/MDR bus: captures one request,
// inserts WAIT_CYC wait states, accesses the store and closes a four-phase handshake.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mm,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               capture;
    logic               mem_en;
    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               rd_valid;
    logic [DATA_W-1:0]  mem_rdata;

    // Next-state logic; a dropped request in WAIT wins over the move to ACCESS.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        mem_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (mm) begin
                    capture    = 1'b1;
                    cnt_next   = WAIT_LOAD;
                    next_state = (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!mm) begin
                    next_state = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        next_state = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                mem_en     = 1'b1;
                next_state = S_DONE;
            end
            S_DONE: begin
                if (!mm) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rdy      <= 1'b0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rw_q     <= RW_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            rdy   <= (next_state == S_DONE);
            busy  <= (next_state != S_IDLE);
            if (capture) begin
                rw_q    <= r_w;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (mem_en && (rw_q == RW_READ)) begin
                rd_valid <= 1'b1;
            end
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (rw_q == RW_WRITE),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // The store's read register has no reset; rdata reads as zero until a read lands.
    assign rdata = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYC=2 and a WAIT_CYC=0 instance checked
// against a word-array model of the store and handshake timing rules.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mm_s, rw_s, rdy_s, busy_s;
    logic [7:0]  addr_s;
    logic [15:0] wdata_s, rdata_s;
    logic        mm_f, rw_f, rdy_f, busy_f;
    logic [7:0]  addr_f;
    logic [15:0] wdata_f, rdata_f;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYC(2)) dut_slow (
        .clk(clk), .rst(rst), .mm(mm_s), .r_w(rw_s), .addr(addr_s),
        .wdata(wdata_s), .rdata(rdata_s), .rdy(rdy_s), .busy(busy_s)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYC(0)) dut_fast (
        .clk(clk), .rst(rst), .mm(mm_f), .r_w(rw_f), .addr(addr_f),
        .wdata(wdata_f), .rdata(rdata_f), .rdy(rdy_f), .busy(busy_f)
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          wait_cyc [2] = '{2, 0};
    logic [15:0] model [2][256];
    logic [15:0] last_read [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic m, input logic rw,
                         input logic [7:0] a, input logic [15:0] d);
        if (w == 0) begin
            mm_s = m; rw_s = rw; addr_s = a; wdata_s = d;
        end else begin
            mm_f = m; rw_f = rw; addr_f = a; wdata_f = d;
        end
    endtask

    function automatic logic obs_rdy(input int w);
        return (w == 0) ? rdy_s : rdy_f;
    endfunction

    function automatic logic obs_busy(input int w);
        return (w == 0) ? busy_s : busy_f;
    endfunction

    function automatic logic [15:0] obs_rdata(input int w);
        return (w == 0) ? rdata_s : rdata_f;
    endfunction

    function automatic logic [7:0] pool_addr(input int i);
        return 8'(i * 37 + 250);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // scramble: 0 = inputs held, 1 = addr FF / data 0 after capture, 2 = random
    task automatic xfer(input int w, input logic rw, input logic [7:0] a,
                        input logic [15:0] d, input int scramble);
        int edges;
        drive(w, 1'b1, rw, a, d);
        edges = 0;
        do begin
            step();
            edges++;
            if (edges == 1) check("busy_after_capture", 32'(obs_busy(w)), 32'd1);
            if (scramble == 1) drive(w, 1'b1, rw, 8'hFF, 16'h0000);
            if (scramble == 2) drive(w, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
        end while (!obs_rdy(w) && edges < 40);
        check("rdy_latency", 32'(edges), 32'(wait_cyc[w] + 2));
        if (rw) begin
            last_read[w] = model[w][a];
            check("rdata_during_rdy", 32'(obs_rdata(w)), 32'(last_read[w]));
        end else begin
            model[w][a] = d;
            check("rdata_kept_on_write", 32'(obs_rdata(w)), 32'(last_read[w]));
        end
        repeat ($urandom_range(1, 3)) begin
            drive(w, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
            step();
            check("rdy_held_mm_high", 32'(obs_rdy(w)), 32'd1);
            check("rdata_stable_in_done", 32'(obs_rdata(w)), 32'(last_read[w]));
        end
        drive(w, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
        step();
        check("rdy_fall", 32'(obs_rdy(w)), 32'd0);
        check("busy_fall", 32'(obs_busy(w)), 32'd0);
        check("rdata_after_rdy", 32'(obs_rdata(w)), 32'(last_read[w]));
    endtask

    task automatic abort_write(input logic [7:0] a, input logic [15:0] d);
        int k;
        k = $urandom_range(1, 2);
        drive(0, 1'b1, 1'b0, a, d);
        repeat (k) step();
        check("abort_busy_in_wait", 32'(busy_s), 32'd1);
        check("abort_rdy_in_wait", 32'(rdy_s), 32'd0);
        drive(0, 1'b0, 1'b0, a, d);
        step();
        check("abort_rdy", 32'(rdy_s), 32'd0);
        check("abort_busy", 32'(busy_s), 32'd0);
    endtask

    task automatic reset_mid_wait(input logic [7:0] a, input logic [15:0] d);
        drive(0, 1'b1, 1'b0, a, d);
        step();
        check("busy_before_reset", 32'(busy_s), 32'd1);
        rst = 1'b0;
        #1;
        check("reset_rdy", 32'(rdy_s), 32'd0);
        check("reset_busy", 32'(busy_s), 32'd0);
        check("reset_rdata", 32'(rdata_s), 32'd0);
        check("reset_rdata_fast", 32'(rdata_f), 32'd0);
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        rst = 1'b1;
        last_read[0] = 16'h0000;
        last_read[1] = 16'h0000;
        step();
        check("busy_after_reset", 32'(busy_s), 32'd0);
    endtask

    initial begin
        int          w;
        logic        rw;
        logic [7:0]  a;
        logic [15:0] d;

        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        last_read[0] = 16'h0000;
        last_read[1] = 16'h0000;
        @(negedge clk);
        step();
        check("por_rdy", 32'(rdy_s), 32'd0);
        check("por_busy", 32'(busy_s), 32'd0);
        check("por_rdata", 32'(rdata_s), 32'd0);
        check("por_rdy_fast", 32'(rdy_f), 32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, pool_addr(i), 16'($urandom), 0);
            xfer(1, 1'b0, pool_addr(i), 16'($urandom), 0);
        end
        xfer(0, 1'b0, 8'h10, 16'h1111, 0);
        xfer(0, 1'b0, 8'h05, 16'h0505, 0);
        xfer(0, 1'b0, 8'h20, 16'h2020, 0);
        xfer(0, 1'b0, 8'h30, 16'h3030, 0);
        xfer(0, 1'b0, 8'hFF, 16'hFFFF, 0);

        reset_mid_wait(8'h10, 16'hBEEF);
        xfer(0, 1'b1, 8'h10, 16'h0000, 0);

        xfer(0, 1'b0, 8'h05, 16'h1234, 0);
        xfer(0, 1'b1, 8'h05, 16'h0000, 0);

        xfer(0, 1'b0, 8'h20, 16'hA5A5, 1);
        xfer(0, 1'b1, 8'h20, 16'h0000, 0);
        xfer(0, 1'b1, 8'hFF, 16'h0000, 0);

        abort_write(8'h30, 16'hDEAD);
        xfer(0, 1'b1, 8'h30, 16'h0000, 0);

        xfer(1, 1'b0, 8'h40, 16'h4444, 0);
        xfer(1, 1'b1, 8'h40, 16'h0000, 0);

        for (int n = 0; n < 60; n++) begin
            w  = $urandom_range(0, 1);
            rw = 1'($urandom_range(0, 1));
            a  = pool_addr($urandom_range(0, 7));
            d  = 16'($urandom);
            if (w == 0 && !rw && $urandom_range(0, 7) == 0) begin
                abort_write(a, d);
            end else begin
                xfer(w, rw, a, d, 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
